// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline slice.
//
// Contents:
//   MAX_PIPE_DEPTH - deepest pipeline the top level will elaborate
//   stage0_src_e   - where stage 0 takes its next beat from
//   clog2_occ()    - width of an occupancy count able to hold n + skid beats
package pipe_pkg;

    localparam int MAX_PIPE_DEPTH = 16;

    // Stage 0 either takes the live input beat or the beat parked in the
    // skid register; the skid always wins because it holds the older beat.
    typedef enum logic {
        SRC_INPUT = 1'b0,
        SRC_SKID  = 1'b1
    } stage0_src_e;

    // The count ranges over 0..n+skid inclusive, hence the +1.
    function automatic int clog2_occ(input int n, input int skid);
        return $clog2(n + skid + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// One stage of the elastic pipeline: a valid bit, a payload register and the
// advance term that lets the stage accept a new beat.
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset, clears valid (and data when
//                  WithReset=1)
//   flush        - synchronous discard of the held beat
//   up_valid     - valid bit offered by the previous stage / input
//   up_data      - payload offered by the previous stage / input
//   down_advance - the following stage (or the consumer) will take our beat
//   advance      - this stage loads from upstream on the next edge
//   valid        - this stage holds a beat
//   data         - payload held by this stage
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter bit WithReset = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DWIDTH-1:0] up_data,
    input  logic              down_advance,
    output logic              advance,
    output logic              valid,
    output logic [DWIDTH-1:0] data
);

    // An empty stage always accepts, which is what collapses bubbles; a full
    // stage accepts only when its beat moves on in the same cycle.
    assign advance = !valid || down_advance;

    // Loading an invalid upstream beat is how a stage empties itself when its
    // beat leaves and nothing follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            if (WithReset) begin
                data <= '0;
            end
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= up_valid;
            data  <= up_data;
        end
    end

endmodule

// File: rtl/pipe_vec_elastic.sv
// N-stage elastic pipeline with valid/ready handshakes on both sides,
// bubble collapsing, synchronous flush, an occupancy count and an optional
// input skid buffer that makes o_ready a registered signal.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset (priority over everything)
//   flush       - synchronous discard of every in-flight beat
//   i_valid     - upstream beat valid
//   o_ready     - a beat can be accepted this cycle
//   i_data      - upstream payload
//   o_valid     - the last stage holds a beat
//   i_ready     - downstream accepts the beat on o_data
//   o_data      - payload of the last stage
//   o_occupancy - number of beats held, skid entry included
module pipe_vec_elastic
    import pipe_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int N         = 2,
    parameter bit WithReset = 1'b0,
    parameter bit SkidInput = 1'b0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        flush,
    input  logic                                        i_valid,
    output logic                                        o_ready,
    input  logic [DWIDTH-1:0]                           i_data,
    output logic                                        o_valid,
    input  logic                                        i_ready,
    output logic [DWIDTH-1:0]                           o_data,
    output logic [clog2_occ(N, int'(SkidInput))-1:0]    o_occupancy
);

    localparam int OCC_W = clog2_occ(N, int'(SkidInput));

    if (N < 1 || N > MAX_PIPE_DEPTH) begin : g_bad_depth
        $error("pipe_vec_elastic: N=%0d is outside 1..%0d", N, MAX_PIPE_DEPTH);
    end

    logic              in_xfer;
    logic              out_xfer;
    logic              s0_valid;
    logic [DWIDTH-1:0] s0_data;
    logic              adv0;
    logic [OCC_W-1:0]  occ_q;

    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    // Each stage gets its own advance net rather than one shared vector, so
    // the ripple from i_ready back to stage 0 is a plain chain of distinct
    // signals and not a vector that feeds itself.
    for (genvar k = 0; k < N; k++) begin : g_stage
        logic              up_valid;
        logic [DWIDTH-1:0] up_data;
        logic              down_adv;
        logic              adv;
        logic              vld;
        logic [DWIDTH-1:0] dat;

        if (k == 0) begin : g_head
            assign up_valid = s0_valid;
            assign up_data  = s0_data;
        end else begin : g_chain
            assign up_valid = g_stage[k-1].vld;
            assign up_data  = g_stage[k-1].dat;
        end

        if (k == N - 1) begin : g_tail
            assign down_adv = i_ready;
        end else begin : g_link
            assign down_adv = g_stage[k+1].adv;
        end

        pipe_stage_elastic #(
            .DWIDTH    (DWIDTH),
            .WithReset (WithReset)
        ) u_stage (
            .clk          (clk),
            .reset        (reset),
            .flush        (flush),
            .up_valid     (up_valid),
            .up_data      (up_data),
            .down_advance (down_adv),
            .advance      (adv),
            .valid        (vld),
            .data         (dat)
        );
    end

    assign adv0    = g_stage[0].adv;
    assign o_valid = g_stage[N-1].vld;
    assign o_data  = g_stage[N-1].dat;

    if (SkidInput) begin : g_skid
        logic              skid_valid;
        logic [DWIDTH-1:0] skid_data;
        stage0_src_e       src;

        // o_ready depends only on the skid flop (plus reset/flush), so the
        // upstream never sees the combinational ripple from i_ready.
        assign src      = skid_valid ? SRC_SKID : SRC_INPUT;
        assign o_ready  = !skid_valid && !flush && !reset;
        assign s0_valid = (src == SRC_SKID) || in_xfer;
        assign s0_data  = (src == SRC_SKID) ? skid_data : i_data;

        // A beat accepted while stage 0 cannot move is parked here; it drains
        // into stage 0 the first cycle stage 0 advances. While parked, o_ready
        // is low, so no second beat can arrive to compete with it.
        always_ff @(posedge clk) begin
            if (reset) begin
                skid_valid <= 1'b0;
                if (WithReset) begin
                    skid_data <= '0;
                end
            end else if (flush) begin
                skid_valid <= 1'b0;
            end else if (skid_valid) begin
                if (adv0) begin
                    skid_valid <= 1'b0;
                end
            end else if (in_xfer && !adv0) begin
                skid_valid <= 1'b1;
                skid_data  <= i_data;
            end
        end
    end else begin : g_direct
        assign o_ready  = adv0 && !flush && !reset;
        assign s0_valid = in_xfer;
        assign s0_data  = i_data;
    end

    // Beats are only created by an input transfer and only destroyed by an
    // output transfer (or flush/reset), so tracking the difference gives the
    // same value as counting the valid bits, without an N-wide popcount.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    assign o_occupancy = occ_q;

endmodule

// File: tb/tb_pipe_vec_elastic.sv
// Self-checking bench for pipe_vec_elastic.
// Four instances run side by side:
//   0: N=3, no skid, WithReset=1  (table-driven latency/stall/flush vectors)
//   1: N=2, skid,    WithReset=1  (skid stall and reset sequences)
//   2: N=4, no skid, WithReset=0  (random traffic)
//   3: N=4, skid,    WithReset=0  (random traffic)
// Every cycle a FIFO-style reference model checks order, occupancy, o_ready
// and stall stability on all four instances.
module tb_pipe_vec_elastic;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [3:0]      iv;
    logic [3:0]      ir;
    logic [3:0]      rdy;
    logic [3:0]      ov;
    logic [3:0][7:0] id;
    logic [3:0][7:0] od;
    logic [1:0]      occ_a;
    logic [1:0]      occ_b;
    logic [2:0]      occ_c;
    logic [2:0]      occ_d;

    int tests = 0;
    int fails = 0;

    // Reference model: one circular buffer of accepted beats per instance.
    logic [7:0] mem [4][64];
    int         head [4];
    int         tail [4];
    bit         prev_stall [4];
    logic [7:0] prev_data [4];
    int         delivered [4];

    typedef struct {
        bit         flush;
        bit         iv;
        logic [7:0] id;
        bit         ir;
        bit         eov;
        logic [7:0] eod;
        bit         erdy;
        int         eocc;
    } vec_t;

    vec_t vecs [33];

    always #5 clk = ~clk;

    pipe_vec_elastic #(.DWIDTH(8), .N(3), .WithReset(1'b1), .SkidInput(1'b0)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .i_valid(iv[0]), .o_ready(rdy[0]),
        .i_data(id[0]), .o_valid(ov[0]), .i_ready(ir[0]), .o_data(od[0]), .o_occupancy(occ_a));

    pipe_vec_elastic #(.DWIDTH(8), .N(2), .WithReset(1'b1), .SkidInput(1'b1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .i_valid(iv[1]), .o_ready(rdy[1]),
        .i_data(id[1]), .o_valid(ov[1]), .i_ready(ir[1]), .o_data(od[1]), .o_occupancy(occ_b));

    pipe_vec_elastic #(.DWIDTH(8), .N(4), .WithReset(1'b0), .SkidInput(1'b0)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .i_valid(iv[2]), .o_ready(rdy[2]),
        .i_data(id[2]), .o_valid(ov[2]), .i_ready(ir[2]), .o_data(od[2]), .o_occupancy(occ_c));

    pipe_vec_elastic #(.DWIDTH(8), .N(4), .WithReset(1'b0), .SkidInput(1'b1)) dut_d (
        .clk(clk), .reset(reset), .flush(flush), .i_valid(iv[3]), .o_ready(rdy[3]),
        .i_data(id[3]), .o_valid(ov[3]), .i_ready(ir[3]), .o_data(od[3]), .o_occupancy(occ_d));

    function automatic int depthOf(input int d);
        case (d)
            0:       return 3;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit skidOf(input int d);
        return (d == 1) || (d == 3);
    endfunction

    function automatic int occOf(input int d);
        case (d)
            0:       return int'(occ_a);
            1:       return int'(occ_b);
            2:       return int'(occ_c);
            default: return int'(occ_d);
        endcase
    endfunction

    function automatic vec_t mk(input bit f, input bit v, input logic [7:0] dat, input bit r,
                                input bit eov, input logic [7:0] eod, input bit erdy, input int eocc);
        vec_t x;
        x.flush = f; x.iv = v; x.id = dat; x.ir = r;
        x.eov = eov; x.eod = eod; x.erdy = erdy; x.eocc = eocc;
        return x;
    endfunction

    // One comparison; the failure line carries name, instance, got and wanted.
    task automatic checkOutput(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drives one table row onto instance 0 (others idle) and lets it settle.
    task automatic applyStimulus(input vec_t v);
        flush   = v.flush;
        iv[0]   = v.iv;
        id[0]   = v.id;
        ir[0]   = v.ir;
        iv[3:1] = '0;
        ir[3:1] = '1;
        #1;
    endtask

    // Reference model step, evaluated after inputs settle and before the edge.
    // Expected o_ready follows from the occupancy alone: without a skid any
    // empty stage lets stage 0 advance, and with a skid the skid is occupied
    // exactly when every entry is full.
    task automatic modelStep();
        for (int d = 0; d < 4; d++) begin
            int cnt;
            bit exp_rdy;
            cnt = tail[d] - head[d];
            if (reset) begin
                checkOutput("rst_o_ready", d, int'(rdy[d]), 0);
                head[d] = tail[d];
                prev_stall[d] = 1'b0;
            end else begin
                if (flush)
                    exp_rdy = 1'b0;
                else if (skidOf(d))
                    exp_rdy = cnt < depthOf(d) + 1;
                else
                    exp_rdy = (cnt < depthOf(d)) || ir[d];
                checkOutput("occupancy", d, occOf(d), cnt);
                checkOutput("o_ready", d, int'(rdy[d]), int'(exp_rdy));
                if (prev_stall[d]) begin
                    checkOutput("stall_valid", d, int'(ov[d]), 1);
                    checkOutput("stall_data", d, int'(od[d]), int'(prev_data[d]));
                end
                if (ov[d] && ir[d]) begin
                    checkOutput("out_nonempty", d, int'(cnt > 0), 1);
                    if (cnt > 0) begin
                        checkOutput("out_data", d, int'(od[d]), int'(mem[d][head[d] % 64]));
                        head[d]++;
                        delivered[d]++;
                    end
                end
                if (iv[d] && rdy[d]) begin
                    mem[d][tail[d] % 64] = id[d];
                    tail[d]++;
                end
                prev_stall[d] = ov[d] && !ir[d];
                prev_data[d]  = od[d];
                if (flush) begin
                    head[d] = tail[d];
                    prev_stall[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic advanceClock();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleAll();
        iv = '0;
        ir = '1;
        id = '0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        int max_b;
        bit saw_bp;
        int base [4];

        for (int d = 0; d < 4; d++) begin
            head[d] = 0; tail[d] = 0; prev_stall[d] = 1'b0; prev_data[d] = '0; delivered[d] = 0;
        end

        // Latency/throughput: 0x01..0x0A back to back into N=3.
        for (int t = 0; t < 14; t++) begin
            vecs[t] = mk(1'b0, t < 10, (t < 10) ? 8'(t + 1) : 8'h00, 1'b1,
                         (t >= 3) && (t <= 12), 8'(t - 2), 1'b1,
                         (t <= 2) ? t : ((t <= 10) ? 3 : 13 - t));
        end
        // Backpressure: fill with i_ready low, then release and drain.
        vecs[14] = mk(0, 1, 8'h01, 0, 0, 8'h00, 1, 0);
        vecs[15] = mk(0, 1, 8'h02, 0, 0, 8'h00, 1, 1);
        vecs[16] = mk(0, 1, 8'h03, 0, 0, 8'h00, 1, 2);
        vecs[17] = mk(0, 1, 8'h04, 0, 1, 8'h01, 0, 3);
        vecs[18] = mk(0, 1, 8'h04, 0, 1, 8'h01, 0, 3);
        vecs[19] = mk(0, 1, 8'h04, 1, 1, 8'h01, 1, 3);
        vecs[20] = mk(0, 0, 8'h00, 1, 1, 8'h02, 1, 3);
        vecs[21] = mk(0, 0, 8'h00, 1, 1, 8'h03, 1, 2);
        vecs[22] = mk(0, 0, 8'h00, 1, 1, 8'h04, 1, 1);
        vecs[23] = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
        // Flush: fill with 0xA0..0xA2, flush (offering 0xEE), then 0x55.
        vecs[24] = mk(0, 1, 8'hA0, 0, 0, 8'h00, 1, 0);
        vecs[25] = mk(0, 1, 8'hA1, 0, 0, 8'h00, 1, 1);
        vecs[26] = mk(0, 1, 8'hA2, 0, 0, 8'h00, 1, 2);
        vecs[27] = mk(1, 1, 8'hEE, 0, 1, 8'hA0, 0, 3);
        vecs[28] = mk(0, 1, 8'h55, 1, 0, 8'h00, 1, 0);
        vecs[29] = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 1);
        vecs[30] = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 1);
        vecs[31] = mk(0, 0, 8'h00, 1, 1, 8'h55, 1, 1);
        vecs[32] = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);

        reset = 1'b1;
        flush = 1'b0;
        idleAll();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            #1;
            advanceClock();
        end
        reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            applyStimulus(vecs[i]);
            checkOutput("tbl_o_valid", i, int'(ov[0]), int'(vecs[i].eov));
            if (vecs[i].eov)
                checkOutput("tbl_o_data", i, int'(od[0]), int'(vecs[i].eod));
            checkOutput("tbl_o_ready", i, int'(rdy[0]), int'(vecs[i].erdy));
            checkOutput("tbl_occupancy", i, occOf(0), vecs[i].eocc);
            advanceClock();
        end

        // Skid instance: stream 0x10.., stall i_ready for 5 cycles mid-stream.
        flush  = 1'b0;
        idleAll();
        sent   = 0;
        max_b  = 0;
        saw_bp = 1'b0;
        base[1] = delivered[1];
        for (int c = 0; c < 20; c++) begin
            iv[1] = sent < 12;
            id[1] = 8'h10 + 8'(sent);
            ir[1] = !((c >= 3) && (c < 8));
            #1;
            if (occOf(1) > max_b) max_b = occOf(1);
            if ((occOf(1) == 3) && !rdy[1]) saw_bp = 1'b1;
            if (iv[1] && rdy[1]) sent++;
            advanceClock();
        end
        idleAll();
        for (int c = 0; c < 6; c++) begin
            #1;
            advanceClock();
        end
        checkOutput("skid_max_occ", 1, max_b, 3);
        checkOutput("skid_backpressure", 1, int'(saw_bp), 1);
        checkOutput("skid_sent", 1, sent, 12);
        checkOutput("skid_delivered", 1, delivered[1] - base[1], 12);

        // Reset mid-stream on instances 0 and 1 (both zero their data).
        for (int c = 0; c < 4; c++) begin
            iv[1:0] = 2'b11;
            id[0] = 8'hC0 + 8'(c);
            id[1] = 8'hD0 + 8'(c);
            ir[1:0] = 2'b00;
            #1;
            advanceClock();
        end
        reset = 1'b1;
        #1;
        advanceClock();
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_o_valid", d, int'(ov[d]), 0);
            checkOutput("rst_o_data", d, int'(od[d]), 0);
            checkOutput("rst_occupancy", d, occOf(d), 0);
        end
        advanceClock();
        reset = 1'b0;
        idleAll();
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("post_rst_o_ready", d, int'(rdy[d]), 1);
            checkOutput("post_rst_o_valid", d, int'(ov[d]), 0);
            checkOutput("post_rst_o_data", d, int'(od[d]), 0);
        end
        advanceClock();

        // Random traffic on every instance, with an occasional flush.
        for (int d = 0; d < 4; d++) base[d] = delivered[d];
        for (int c = 0; c < 10000; c++) begin
            for (int d = 0; d < 4; d++) begin
                iv[d] = 1'($urandom_range(0, 1));
                ir[d] = 1'($urandom_range(0, 1));
                id[d] = 8'($urandom);
            end
            flush = ($urandom_range(0, 999) == 0);
            #1;
            advanceClock();
        end
        flush = 1'b0;
        idleAll();
        for (int c = 0; c < 10; c++) begin
            #1;
            advanceClock();
        end
        for (int d = 0; d < 4; d++) begin
            checkOutput("rand_drained", d, tail[d] - head[d], 0);
        end
        for (int d = 2; d < 4; d++) begin
            checkOutput("rand_throughput", d, int'(delivered[d] - base[d] > 1000), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
